// File: rtl/alarm_clock_pkg.sv
// Shared alarm-clock definitions: keypad scanner states, NOKEY code and key map.
package alarm_clock_pkg;

    localparam logic [3:0] NOKEY = 4'd10;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        EMIT     = 2'd2,
        HOLD     = 2'd3
    } scan_state_t;

    // Rows 0..2 carry digits 1..9; row 3 is *, 0, # where only the middle key is a digit.
    function automatic logic [3:0] key_decode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        code = NOKEY;
        if (r == 2'd3) begin
            if (c == 2'd1) code = 4'd0;
        end else begin
            code = {2'b00, r} * 4'd3 + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and key-buffer signals; master is the scanner, slave the pins/consumer side.
interface keypad_scanner_if;
    logic [3:0] row;
    logic [2:0] col;
    logic [3:0] key;
    logic       shift;

    modport master (input row, output col, output key, output shift);
    modport slave  (output row, input col, input key, input shift);
endinterface

// File: rtl/keypad_scanner_key_sync.sv
// Two-flop synchroniser for asynchronous pin inputs, parameterised width.
module key_sync #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/keypad_scanner.sv
// 4x3 keypad scanner: column scan, row debounce, one shift pulse per digit press.
module keypad_scanner
    import alarm_clock_pkg::*;
#(
    parameter int unsigned SCAN_DWELL      = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset,
    keypad_scanner_if.master    pad
);
    localparam int unsigned DW = $clog2(SCAN_DWELL);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DWELL - 1);
    localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] DB_FULL    = CW'(DEBOUNCE_CYCLES);

    logic [3:0] row_s;

    key_sync #(.WIDTH(4)) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (pad.row),
        .q     (row_s)
    );

    scan_state_t   state_q, state_d;
    logic [2:0]    col_q, col_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cap_row_q, cap_row_d;
    logic [3:0]    code_q, code_d;
    logic [3:0]    key_q, key_d;
    logic          shift_q, shift_d;
    logic [1:0]    row_idx, col_idx;
    logic [2:0]    col_next;

    always_comb begin
        row_idx = 2'd0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (row_s[i]) row_idx = 2'(i);
        end
        col_idx  = col_q[1] ? 2'd1 : (col_q[2] ? 2'd2 : 2'd0);
        col_next = {col_q[1:0], col_q[2]};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SCAN;
            col_q     <= 3'b001;
            dwell_q   <= '0;
            cnt_q     <= '0;
            cap_row_q <= '0;
            code_q    <= NOKEY;
            key_q     <= NOKEY;
            shift_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            dwell_q   <= dwell_d;
            cnt_q     <= cnt_d;
            cap_row_q <= cap_row_d;
            code_q    <= code_d;
            key_q     <= key_d;
            shift_q   <= shift_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        dwell_d   = dwell_q;
        cnt_d     = cnt_q;
        cap_row_d = cap_row_q;
        code_d    = code_q;

        unique case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    if ((row_s != '0) && $onehot(row_s)) begin
                        cap_row_d = row_s;
                        code_d    = key_decode(row_idx, col_idx);
                        cnt_d     = CW'(1);
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = col_next;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_s == cap_row_q) begin
                    if (cnt_q >= DB_LAST) begin
                        cnt_d   = DB_FULL;
                        state_d = EMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    state_d = SCAN;
                    col_d   = col_next;
                    dwell_d = '0;
                    cnt_d   = '0;
                end
            end
            EMIT: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                // The counter tracks consecutive clean zero samples of the release.
                if (row_s == '0) begin
                    if (cnt_q >= DB_LAST) begin
                        state_d = SCAN;
                        col_d   = 3'b001;
                        dwell_d = '0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end
        endcase

        // Outputs are registered against the next state so they line up with it.
        key_d   = ((state_d == EMIT) || (state_d == HOLD)) ? code_d : NOKEY;
        shift_d = (state_d == EMIT) && (code_d != NOKEY);
    end

    assign pad.col   = col_q;
    assign pad.key   = key_q;
    assign pad.shift = shift_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model driving the rows.
module tb_keypad_scanner;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic [2:0] pressed [4];
    int cyc;
    int tests = 0;
    int failures = 0;
    int shift_cnt;
    int shift_cyc;
    int shift_key;

    always #5 clock = ~clock;

    keypad_scanner_if pad ();

    keypad_scanner #(.SCAN_DWELL(4), .DEBOUNCE_CYCLES(4)) dut (
        .clock (clock),
        .reset (reset),
        .pad   (pad)
    );

    // A pressed key connects its row to its column only while that column is driven.
    assign pad.row = {|(pressed[3] & pad.col), |(pressed[2] & pad.col),
                      |(pressed[1] & pad.col), |(pressed[0] & pad.col)};

    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clock) begin
        if (reset) begin
            shift_cnt <= 0;
            shift_cyc <= -1;
            shift_key <= -1;
        end else if (pad.shift) begin
            shift_cnt <= shift_cnt + 1;
            shift_cyc <= cyc;
            shift_key <= int'(pad.key);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++) pressed[r] = 3'b000;
    endtask

    // Leaves the bench in cycle 0: the last edge saw reset high, the next will not.
    task automatic do_reset();
        reset = 1'b1;
        release_all();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic check_idle_rotation(input string tag);
        logic [2:0] exp_col;
        for (int n = 0; n < 30; n++) begin
            run_to(n);
            exp_col = 3'b001 << ((n / 4) % 3);
            check({tag, "_col"}, int'(pad.col), int'(exp_col));
            check({tag, "_key"}, int'(pad.key), 10);
        end
        check({tag, "_noshift"}, shift_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        release_all();
        do_reset();
        check("rst_col", int'(pad.col), 1);
        check("rst_key", int'(pad.key), 10);
        check("rst_shift", int'(pad.shift), 0);

        check_idle_rotation("idle");

        // Key 5: visible from cycle 4, sampled cycle 7, debounced 8..10, EMIT cycle 11.
        do_reset();
        pressed[1] = 3'b010;
        run_to(10);
        check("k5_early", shift_cnt, 0);
        run_to(11);
        check("k5_shift", int'(pad.shift), 1);
        check("k5_key_emit", int'(pad.key), 5);
        run_to(12);
        check("k5_pulse_end", int'(pad.shift), 0);
        check("k5_key_hold", int'(pad.key), 5);
        check("k5_col_frozen", int'(pad.col), 2);
        run_to(40);
        pressed[1] = 3'b000;
        run_to(45);
        check("k5_key_before_rel", int'(pad.key), 5);
        run_to(46);
        check("k5_key_released", int'(pad.key), 10);
        check("k5_col_restart", int'(pad.col), 1);
        check("k5_one_shift", shift_cnt, 1);
        check("k5_shift_cycle", shift_cyc, 11);

        // Key 0 bounce: the first blip is caught then lost in DEBOUNCE, next pass in c1 emits at 24.
        do_reset();
        run_to(5);
        pressed[3] = 3'b010;
        run_to(6);
        pressed[3] = 3'b000;
        run_to(7);
        pressed[3] = 3'b010;
        run_to(23);
        check("k0_no_early", shift_cnt, 0);
        run_to(24);
        check("k0_shift", int'(pad.shift), 1);
        check("k0_key", int'(pad.key), 0);
        run_to(40);
        check("k0_no_repeat", shift_cnt, 1);
        pressed[3] = 3'b000;
        run_to(50);
        check("k0_total", shift_cnt, 1);
        check("k0_shift_cycle", shift_cyc, 24);

        // Star: detected and held (column frozen), never pulses, key stays NOKEY.
        do_reset();
        pressed[3] = 3'b001;
        for (int n = 1; n <= 40; n++) begin
            run_to(n);
            check("star_key", int'(pad.key), 10);
            if (n == 5 || n == 20 || n == 40) check("star_col_frozen", int'(pad.col), 1);
        end
        check("star_noshift", shift_cnt, 0);

        // Keys 1 and 4 together in column 0: ignored, scanning continues.
        do_reset();
        pressed[0] = 3'b001;
        pressed[1] = 3'b001;
        check_idle_rotation("multi");

        // Key 9 would EMIT in cycle 15; reset sampled on that edge suppresses the pulse.
        do_reset();
        pressed[2] = 3'b100;
        run_to(14);
        check("k9_pre_shift", int'(pad.shift), 0);
        check("k9_pre_key", int'(pad.key), 10);
        reset = 1'b1;
        release_all();
        step();
        check("k9_rst_shift", int'(pad.shift), 0);
        check("k9_rst_key", int'(pad.key), 10);
        check("k9_rst_col", int'(pad.col), 1);
        reset = 1'b0;
        run_to(29);
        check("k9_quiet", shift_cnt, 0);
        run_to(30);
        pressed[2] = 3'b100;
        run_to(38);
        check("k9_fresh_early", shift_cnt, 0);
        run_to(39);
        check("k9_fresh_shift", int'(pad.shift), 1);
        check("k9_fresh_key", int'(pad.key), 9);
        run_to(45);
        check("k9_fresh_total", shift_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
